// File: rtl/frame_wr_burst_gen_pkg.sv
// Shared definitions for the frame write-burst generator and its read-side sibling:
// FSM state encoding, a constant-friendly ceil(log2) helper and the beat-size shift.
package frame_wr_burst_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARM  = 3'd1,
    ST_WAIT = 3'd2,
    ST_CMD  = 3'd3,
    ST_DATA = 3'd4,
    ST_DONE = 3'd5
  } state_e;

  // Smallest r with 2**r >= value; usable in parameter expressions.
  function automatic int clog2_f(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        result = i + 1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

  localparam int BEAT_BYTES_DEF = 16;
  localparam int BEAT_SHIFT_DEF = clog2_f(BEAT_BYTES_DEF);

endpackage

// File: rtl/frame_wr_burst_gen_if.sv
// DDR write-command and data-beat channel between the burst generator (master)
// and the memory controller (slave).
interface frame_wr_burst_gen_if #(
  parameter int ADDR_W = 28
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [7:0]        cmd_len;
  logic              data_beat;

  modport master (
    output cmd_valid,
    output cmd_addr,
    output cmd_len,
    input  cmd_ready,
    input  data_beat
  );

  modport slave (
    input  cmd_valid,
    input  cmd_addr,
    input  cmd_len,
    output cmd_ready,
    output data_beat
  );

endinterface

// File: rtl/frame_wr_burst_gen_vs_edge_det.sv
// Vsync rising-edge detector: registers the level and flags the cycle in which it
// goes high. Shared by the write and read frame sides.
module vs_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise
);

  logic sig_d;
  logic sig_q;

  // Next value of the delayed level.
  always_comb begin
    sig_d = sig;
  end

  // Delayed copy of the level, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign rise = sig & ~sig_q;

endmodule

// File: rtl/frame_wr_burst_gen.sv
// Splits each write frame into DDR write bursts, gating every burst on the pixel
// FIFO level and tracking accepted beats; a vsync mid-frame restarts on the new slot.
module frame_wr_burst_gen
  import frame_wr_burst_gen_pkg::*;
#(
  parameter int ADDR_W      = 28,
  parameter int FRAME_SHIFT = 23,
  parameter int BEAT_BYTES  = 16,
  parameter int BURST_LEN   = 64,
  parameter int FRAME_BEATS = 259200,
  parameter int CNT_W       = 10
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic                  wr_vs,
  input  logic [2:0]            wr_base,
  input  logic [CNT_W-1:0]      fifo_rd_cnt,
  frame_wr_burst_gen_if.master  cmd_if,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  err_overrun
);

  localparam int BEAT_SHIFT = clog2_f(BEAT_BYTES);
  localparam int OFF_W      = clog2_f(FRAME_BEATS + 1);
  localparam logic [OFF_W-1:0] FRAME_BEATS_C = OFF_W'(FRAME_BEATS);

  state_e            state_q,      state_d;
  logic [2:0]        base_q,       base_d;
  logic [OFF_W-1:0]  offset_q,     offset_d;
  logic [7:0]        beat_cnt_q,   beat_cnt_d;
  logic              restart_q,    restart_d;
  logic              cmd_valid_q,  cmd_valid_d;
  logic [ADDR_W-1:0] cmd_addr_q,   cmd_addr_d;
  logic [7:0]        cmd_len_q,    cmd_len_d;
  logic              busy_q,       busy_d;
  logic              frame_done_q, frame_done_d;
  logic              err_q,        err_d;

  logic              vs_rise_s;
  logic [OFF_W-1:0]  rem_s;
  logic [7:0]        len_s;
  logic [ADDR_W-1:0] addr_s;
  logic              restart_now_s;

  vs_edge_det u_vs_edge (
    .clk  (wclk),
    .rst  (wrst),
    .sig  (wr_vs),
    .rise (vs_rise_s)
  );

  // Remaining beats, next burst length and its start address for the current offset.
  always_comb begin
    rem_s = FRAME_BEATS_C - offset_q;
    if (32'(rem_s) < 32'(BURST_LEN)) begin
      len_s = 8'(rem_s);
    end else begin
      len_s = 8'(BURST_LEN);
    end
    addr_s = (ADDR_W'(base_q) << FRAME_SHIFT) + (ADDR_W'(offset_q) << BEAT_SHIFT);
    restart_now_s = restart_q | vs_rise_s;
  end

  // Next-state logic; registered outputs are derived from the upcoming state.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    offset_d   = offset_q;
    beat_cnt_d = beat_cnt_q;
    restart_d  = restart_q;
    cmd_addr_d = cmd_addr_q;
    cmd_len_d  = cmd_len_q;
    err_d      = err_q;
    case (state_q)
      ST_IDLE: begin
        if (vs_rise_s) state_d = ST_ARM;
        else           state_d = ST_IDLE;
      end
      ST_ARM: begin
        // Slot is taken one cycle after the edge so the encoder output has settled.
        base_d     = wr_base;
        offset_d   = '0;
        beat_cnt_d = 8'd0;
        restart_d  = 1'b0;
        if (vs_rise_s) begin
          err_d   = 1'b1;
          state_d = ST_ARM;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (vs_rise_s) begin
          err_d   = 1'b1;
          state_d = ST_ARM;
        end else if (rem_s == '0) begin
          state_d = ST_DONE;
        end else if (32'(fifo_rd_cnt) >= 32'(len_s)) begin
          state_d    = ST_CMD;
          cmd_len_d  = len_s;
          cmd_addr_d = addr_s;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_CMD: begin
        if (vs_rise_s) begin
          err_d     = 1'b1;
          restart_d = 1'b1;
        end else begin
          restart_d = restart_q;
        end
        if (cmd_if.cmd_ready) state_d = ST_DATA;
        else                  state_d = ST_CMD;
      end
      ST_DATA: begin
        // A burst already on the bus cannot be cancelled; a restart waits for its end.
        if (vs_rise_s) err_d = 1'b1;
        else           err_d = err_q;
        if (cmd_if.data_beat && (beat_cnt_q == (cmd_len_q - 8'd1))) begin
          offset_d   = offset_q + OFF_W'(cmd_len_q);
          beat_cnt_d = 8'd0;
          restart_d  = 1'b0;
          if (restart_now_s) state_d = ST_ARM;
          else               state_d = ST_WAIT;
        end else if (cmd_if.data_beat) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
          restart_d  = restart_now_s;
        end else begin
          restart_d  = restart_now_s;
        end
      end
      ST_DONE: begin
        if (vs_rise_s) state_d = ST_ARM;
        else           state_d = ST_IDLE;
      end
      default: begin
        state_d    = ST_IDLE;
        restart_d  = 1'b0;
        beat_cnt_d = 8'd0;
      end
    endcase
    cmd_valid_d  = (state_d == ST_CMD);
    busy_d       = (state_d != ST_IDLE);
    frame_done_d = (state_d == ST_DONE);
  end

  // State, counters and output registers.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      state_q      <= ST_IDLE;
      base_q       <= 3'd0;
      offset_q     <= '0;
      beat_cnt_q   <= 8'd0;
      restart_q    <= 1'b0;
      cmd_valid_q  <= 1'b0;
      cmd_addr_q   <= '0;
      cmd_len_q    <= 8'd0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      offset_q     <= offset_d;
      beat_cnt_q   <= beat_cnt_d;
      restart_q    <= restart_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_len_q    <= cmd_len_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
    end
  end

  assign cmd_if.cmd_valid = cmd_valid_q;
  assign cmd_if.cmd_addr  = cmd_addr_q;
  assign cmd_if.cmd_len   = cmd_len_q;
  assign busy             = busy_q;
  assign frame_done       = frame_done_q;
  assign err_overrun      = err_q;

endmodule
